cntr8_ud: RTL and testbench
===========================

CNTR8_UD -- requirements
Module: cntr8_ud

Interface
REQ-001 Parameter STEP, default 8'd1: unsigned 8-bit amount added or subtracted per count event; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 load  input  1  load request; highest-priority command.
REQ-005 inc  input  1  count-up request.
REQ-006 dec  input  1  count-down request.
REQ-007 d_in  input  8  value captured when load is sampled high.
REQ-008 o_cnt  output  8  registered counter value.
REQ-009 o_state  output  3  registered FSM state code.
REQ-010 o_co  output  1  one-cycle carry/overflow pulse.
REQ-011 o_bo  output  1  one-cycle borrow/underflow pulse.

Function
REQ-012 FSM states and codes SHALL be IDLE=3'b000, LOAD=3'b001, INC=3'b010, DEC=3'b011, HOLD=3'b100.
REQ-013 Next state from any state SHALL be: load=1 -> LOAD; else inc=1 and dec=1 -> HOLD; else inc=1 -> INC; else dec=1 -> DEC; else IDLE.
REQ-014 Command priority SHALL be load > (inc and dec together) > inc > dec.
REQ-015 o_cnt and o_state SHALL update on the same clock edge that samples the command, giving 1-cycle latency from input to output.
REQ-016 LOAD SHALL set o_cnt to d_in. INC SHALL set o_cnt to (o_cnt + STEP). DEC SHALL set o_cnt to (o_cnt - STEP). IDLE and HOLD SHALL leave o_cnt unchanged.
REQ-017 Addition SHALL use 8-bit adder semantics with carry-in 0 and a 9th carry bit.
REQ-018 Subtraction SHALL use the same adder with ~STEP as the operand and carry-in 1; borrow is the inverse of the carry-out.
REQ-019 Without saturation, results SHALL wrap modulo 256.
REQ-020 o_co SHALL be 1 for exactly the cycle after an INC whose addition carried out of bit 7, and 0 otherwise.
REQ-021 o_bo SHALL be 1 for exactly the cycle after a DEC that borrowed, and 0 otherwise.
REQ-022 o_co and o_bo SHALL never be 1 in the same cycle; LOAD and HOLD SHALL clear both.
REQ-023 Sustained inc SHALL count once per clock with no idle cycle required between counts.

Reset
REQ-024 When reset is sampled high, o_cnt SHALL become 8'h00, o_state IDLE, and o_co and o_bo 0, overriding all commands.
REQ-025 A reset arriving mid-sequence SHALL discard the command sampled in that cycle; counting resumes from 8'h00 on the first cycle after reset deasserts.
REQ-026 Before the first reset, outputs SHALL NOT be relied upon.

Configuration
REQ-027 Macro CNTR8_SAT_EN defined: INC that would carry SHALL set o_cnt to 8'hFF; DEC that would borrow SHALL set o_cnt to 8'h00.
REQ-028 In saturating mode, o_co and o_bo SHALL still pulse on the clipped operation, and SHALL pulse on every repeated clipped operation.
REQ-029 CNTR8_SAT_EN undefined: wrap behaviour per REQ-019 applies, and no saturation logic SHALL be present.

Verification
REQ-030 Reset high for 2 cycles with inc=1 -> o_cnt=8'h00, o_state=3'b000, o_co=0, o_bo=0.
REQ-031 load=1, d_in=8'hFE, then inc for 3 cycles (STEP=1, no SAT) -> o_cnt sequence FE, FF, 00, 01; o_co=1 only with o_cnt=00.
REQ-032 load 8'h01, then dec for 2 cycles -> o_cnt 00 then FF; o_bo=1 only with o_cnt=FF; with CNTR8_SAT_EN -> 00 then 00, with o_bo=1 on the second cycle.
REQ-033 load=1, inc=1, dec=1, d_in=8'h5A in one cycle -> o_cnt=8'h5A, o_state=LOAD; next cycle inc=dec=1 -> o_cnt=8'h5A, o_state=HOLD.
REQ-034 STEP=8'd100, load 8'hC8, then inc -> o_cnt=8'h2C with o_co=1 (no SAT), or 8'hFF with o_co=1 (SAT).
REQ-035 Reset asserted during an inc burst at o_cnt=8'h37 -> next o_cnt=8'h00; first inc after release -> 8'h01.

Source files
------------

// File: rtl/cntr8_ud_if.sv
// cntr8_ud_if: command/status bundle for the cntr8_ud up/down counter.
// master drives load/inc/dec/d_in and observes the counter outputs;
// slave is the counter side (receives commands, drives o_cnt/o_state/o_co/o_bo).
interface cntr8_ud_if;
    logic       load;
    logic       inc;
    logic       dec;
    logic [7:0] d_in;
    logic [7:0] o_cnt;
    logic [2:0] o_state;
    logic       o_co;
    logic       o_bo;

    modport master (
        output load, inc, dec, d_in,
        input  o_cnt, o_state, o_co, o_bo
    );

    modport slave (
        input  load, inc, dec, d_in,
        output o_cnt, o_state, o_co, o_bo
    );
endinterface

// File: rtl/cntr8_ud.sv
// cntr8_ud: 8-bit loadable up/down counter with registered FSM state and
// one-cycle carry/borrow pulses; STEP sets the per-event increment (1..255).
// Ports: clk, reset (sync, active-high), bus (cntr8_ud_if.slave):
//   load/inc/dec/d_in commands in; o_cnt/o_state/o_co/o_bo registered out.
// Build option: define CNTR8_SAT_EN to clip at 8'hFF / 8'h00 instead of wrapping.
module cntr8_ud #(
    parameter logic [7:0] STEP = 8'd1
) (
    input  logic        clk,
    input  logic        reset,
    cntr8_ud_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        DEC  = 3'b011,
        HOLD = 3'b100
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       co;
    logic       bo;

    // Priority-resolved commands; exactly one is true every cycle.
    logic cmd_load;
    logic cmd_hold;
    logic cmd_inc;
    logic cmd_dec;
    logic cmd_idle;

    always_comb begin
        cmd_load = bus.load;
        cmd_hold = !bus.load && bus.inc && bus.dec;
        cmd_inc  = !bus.load && bus.inc && !bus.dec;
        cmd_dec  = !bus.load && !bus.inc && bus.dec;
        cmd_idle = !bus.load && !bus.inc && !bus.dec;
    end

    // One shared adder: subtraction adds ~STEP with carry-in 1,
    // so a missing carry-out means the subtraction borrowed.
    logic [7:0] operand;
    logic       cin;
    logic [8:0] sum;
    logic       carry;
    logic       borrow;
    logic [7:0] inc_res;
    logic [7:0] dec_res;

    always_comb begin
        operand = cmd_dec ? ~STEP : STEP;
        cin     = cmd_dec;
        sum     = {1'b0, cnt} + {1'b0, operand} + {8'b0, cin};
        carry   = sum[8];
        borrow  = ~sum[8];
`ifdef CNTR8_SAT_EN
        inc_res = carry  ? 8'hFF : sum[7:0];
        dec_res = borrow ? 8'h00 : sum[7:0];
`else
        inc_res = sum[7:0];
        dec_res = sum[7:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'h00;
            co    <= 1'b0;
            bo    <= 1'b0;
        end else begin
            co <= 1'b0;
            bo <= 1'b0;
            unique case (1'b1)
                cmd_load: begin
                    state <= LOAD;
                    cnt   <= bus.d_in;
                end
                cmd_hold: begin
                    state <= HOLD;
                end
                cmd_inc: begin
                    state <= INC;
                    cnt   <= inc_res;
                    co    <= carry;
                end
                cmd_dec: begin
                    state <= DEC;
                    cnt   <= dec_res;
                    bo    <= borrow;
                end
                cmd_idle: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_cnt   = cnt;
    assign bus.o_state = state;
    assign bus.o_co    = co;
    assign bus.o_bo    = bo;

endmodule

// File: tb/tb_cntr8_ud.sv
// tb_cntr8_ud: self-checking bench for cntr8_ud (STEP=1 and STEP=100 copies),
// directed scenarios plus random commands against an arithmetic reference model.
module tb_cntr8_ud;

`ifdef CNTR8_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cntr8_ud_if ba ();
    cntr8_ud_if bb ();

    cntr8_ud #(.STEP(8'd1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ba.slave)
    );

    cntr8_ud #(.STEP(8'd100)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bb.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state, one set per counter copy.
    int ma_cnt, ma_st;
    bit ma_co, ma_bo;
    int mb_cnt, mb_st;
    bit mb_co, mb_bo;

    task automatic model(
        input int step, input bit r, input bit l, input bit i,
        input bit d, input int v,
        inout int cnt, inout int st, inout bit co, inout bit bo
    );
        int t;
        co = 1'b0;
        bo = 1'b0;
        if (r) begin
            cnt = 0;
            st  = 0;
        end else if (l) begin
            cnt = v;
            st  = 1;
        end else if (i && d) begin
            st = 4;
        end else if (i) begin
            t   = cnt + step;
            st  = 2;
            co  = (t > 255);
            cnt = co ? (SAT ? 255 : t - 256) : t;
        end else if (d) begin
            t   = cnt - step;
            st  = 3;
            bo  = (t < 0);
            cnt = bo ? (SAT ? 0 : t + 256) : t;
        end else begin
            st = 0;
        end
    endtask

    function automatic logic [12:0] got_a();
        return {ba.o_cnt, ba.o_state, ba.o_co, ba.o_bo};
    endfunction

    function automatic logic [12:0] got_b();
        return {bb.o_cnt, bb.o_state, bb.o_co, bb.o_bo};
    endfunction

    function automatic logic [12:0] exp_a();
        return {ma_cnt[7:0], ma_st[2:0], ma_co, ma_bo};
    endfunction

    function automatic logic [12:0] exp_b();
        return {mb_cnt[7:0], mb_st[2:0], mb_co, mb_bo};
    endfunction

    // Apply one command cycle to both copies and advance the model.
    task automatic cycle(
        input bit r, input bit l, input bit i,
        input bit d, input logic [7:0] v
    );
        @(negedge clk);
        reset   = r;
        ba.load = l;  ba.inc = i;  ba.dec = d;  ba.d_in = v;
        bb.load = l;  bb.inc = i;  bb.dec = d;  bb.d_in = v;
        @(posedge clk);
        #1;
        model(1, r, l, i, d, int'(v), ma_cnt, ma_st, ma_co, ma_bo);
        model(100, r, l, i, d, int'(v), mb_cnt, mb_st, mb_co, mb_bo);
    endtask

    task automatic test_reset();
        cycle(1, 0, 1, 0, 8'h00);
        cycle(1, 0, 1, 0, 8'h00);
        checks++;
        if (got_a() !== 13'h0000) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", got_a(), 13'h0000);
        end
        checks++;
        if (got_b() !== 13'h0000) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", got_b(), 13'h0000);
        end
    endtask

    task automatic test_wrap_up();
        logic [7:0] ec [4];
        logic       eo [4];
        if (SAT) begin
            ec = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
            eo = '{1'b0, 1'b0, 1'b1, 1'b1};
        end else begin
            ec = '{8'hFE, 8'hFF, 8'h00, 8'h01};
            eo = '{1'b0, 1'b0, 1'b1, 1'b0};
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, k == 0, k != 0, 0, 8'hFE);
            checks++;
            if (ba.o_cnt !== ec[k] || ba.o_co !== eo[k]) begin
                failures++;
                $display("FAIL wrap_up[%0d] got cnt=%h co=%b exp cnt=%h co=%b",
                         k, ba.o_cnt, ba.o_co, ec[k], eo[k]);
            end
        end
    endtask

    task automatic test_borrow();
        logic [7:0] ec [3];
        logic       eb [3];
        if (SAT) ec = '{8'h01, 8'h00, 8'h00};
        else     ec = '{8'h01, 8'h00, 8'hFF};
        eb = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            cycle(0, k == 0, 0, k != 0, 8'h01);
            checks++;
            if (ba.o_cnt !== ec[k] || ba.o_bo !== eb[k] || ba.o_co !== 1'b0) begin
                failures++;
                $display("FAIL borrow[%0d] got cnt=%h bo=%b co=%b exp cnt=%h bo=%b co=0",
                         k, ba.o_cnt, ba.o_bo, ba.o_co, ec[k], eb[k]);
            end
        end
    endtask

    task automatic test_priority();
        cycle(0, 1, 1, 1, 8'h5A);
        checks++;
        if (ba.o_cnt !== 8'h5A || ba.o_state !== 3'b001) begin
            failures++;
            $display("FAIL prio_load got cnt=%h st=%b exp cnt=5a st=001",
                     ba.o_cnt, ba.o_state);
        end
        cycle(0, 0, 1, 1, 8'h00);
        checks++;
        if (ba.o_cnt !== 8'h5A || ba.o_state !== 3'b100 ||
            ba.o_co !== 1'b0 || ba.o_bo !== 1'b0) begin
            failures++;
            $display("FAIL prio_hold got cnt=%h st=%b exp cnt=5a st=100",
                     ba.o_cnt, ba.o_state);
        end
    endtask

    task automatic test_step100();
        logic [7:0] ec;
        ec = SAT ? 8'hFF : 8'h2C;
        cycle(0, 1, 0, 0, 8'hC8);
        cycle(0, 0, 1, 0, 8'h00);
        checks++;
        if (bb.o_cnt !== ec || bb.o_co !== 1'b1 || bb.o_state !== 3'b010) begin
            failures++;
            $display("FAIL step100 got cnt=%h co=%b st=%b exp cnt=%h co=1 st=010",
                     bb.o_cnt, bb.o_co, bb.o_state, ec);
        end
        cycle(0, 0, 1, 0, 8'h00);
        checks++;
        if (got_b() !== exp_b()) begin
            failures++;
            $display("FAIL step100_again got=%h exp=%h", got_b(), exp_b());
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 0, 0, 8'h35);
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 0, 1, 0, 8'h00);
        checks++;
        if (ba.o_cnt !== 8'h37) begin
            failures++;
            $display("FAIL rst_mid_pre got=%h exp=37", ba.o_cnt);
        end
        cycle(1, 0, 1, 0, 8'h00);
        checks++;
        if (got_a() !== 13'h0000) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=%h", got_a(), 13'h0000);
        end
        cycle(0, 0, 1, 0, 8'h00);
        checks++;
        if (ba.o_cnt !== 8'h01 || ba.o_state !== 3'b010) begin
            failures++;
            $display("FAIL rst_mid_post got cnt=%h st=%b exp cnt=01 st=010",
                     ba.o_cnt, ba.o_state);
        end
    endtask

    task automatic test_back_to_back();
        cycle(0, 1, 0, 0, 8'hF0);
        for (int k = 0; k < 24; k++) begin
            cycle(0, 0, 1, 0, 8'h00);
            checks++;
            if (got_a() !== exp_a() || got_b() !== exp_b()) begin
                failures++;
                $display("FAIL b2b[%0d] got a=%h b=%h exp a=%h b=%h",
                         k, got_a(), got_b(), exp_a(), exp_b());
            end
        end
    endtask

    task automatic test_random();
        bit r, l, i, d;
        logic [7:0] v;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 7) == 0);
            i = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
            v = 8'($urandom);
            cycle(r, l, i, d, v);
            checks++;
            if (got_a() !== exp_a() || got_b() !== exp_b()) begin
                failures++;
                $display("FAIL random[%0d] got a=%h b=%h exp a=%h b=%h",
                         k, got_a(), got_b(), exp_a(), exp_b());
            end
            checks++;
            if (ba.o_co && ba.o_bo) begin
                failures++;
                $display("FAIL random_cobo[%0d] got co=1 bo=1 exp not both", k);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        ba.load = 1'b0;  ba.inc = 1'b0;  ba.dec = 1'b0;  ba.d_in = 8'h00;
        bb.load = 1'b0;  bb.inc = 1'b0;  bb.dec = 1'b0;  bb.d_in = 8'h00;
        test_reset();
        test_wrap_up();
        test_borrow();
        test_priority();
        test_step100();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
